// File: rtl/trap_pkg.sv
// Shared definitions for the I/O-protection trap sequencer: state encoding,
// NMI vector address, control-register bit indices and the port-window check.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INHIBIT    = 3'd1,
        NMI_ASSERT = 3'd2,
        NMI_WAIT   = 3'd3,
        HANDLER    = 3'd4
    } trap_state_e;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;

    localparam int USER_MODE_BIT = 0;
    localparam int TRAP_EN_BIT   = 1;

    // True when the port lies inside the window user code may touch.
    function automatic logic port_allowed(input logic [7:0] port,
                                          input logic [7:0] base,
                                          input logic [7:0] mask);
        return ((port & mask) == base);
    endfunction

endpackage

// File: rtl/nmi_pulse_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module nmi_pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/io_trap_sequencer.sv
// MegaMapper Nabu I/O-protection trap sequencer. Optional saturating trap
// counter is built only when IO_TRAP_COUNTER_EN is defined.
module io_trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [7:0]  ALLOW_BASE  = 8'h40,
    parameter logic [7:0]  ALLOW_MASK  = 8'hC0,
    parameter int unsigned NMI_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic [15:0] addr,
    input  logic        user_mode,
    input  logic        trap_en,
    input  logic        clear_violation,
    output logic        record_isr_en,
    output logic        io_violation_occured,
    output logic        io_inhibit,
    output logic        nmi_n,
    output logic [7:0]  trap_count
);

    // Counters are loaded with N-1 so the zero flag marks the Nth clock.
    localparam logic [7:0] NMI_LOAD = 8'(NMI_CYCLES - 1);
    localparam logic [7:0] TO_LOAD  = 8'(ACK_TIMEOUT - 1);

    trap_state_e state_r, state_s;
    logic        iorq_d_r;
    logic        rec_r, rec_s;
    logic        viol_r, viol_s;
    logic        inh_r, inh_s;
    logic        nmi_r, nmi_s;
    logic        nmi_load_s, nmi_dec_s, nmi_zero_s;
    logic        to_load_s, to_dec_s, to_zero_s;
    logic [1:0]  ctrl_s;
    logic        armed_s, io_fall_s, violation_s, vec_fetch_s;

    assign ctrl_s      = {trap_en, user_mode};
    assign armed_s     = ctrl_s[USER_MODE_BIT] & ctrl_s[TRAP_EN_BIT];
    // Interrupt acknowledge (IORQ with M1) is never a port access.
    assign io_fall_s   = ~iorq_n & iorq_d_r & m1_n;
    assign violation_s = io_fall_s & armed_s & ~port_allowed(addr[7:0], ALLOW_BASE, ALLOW_MASK);
    assign vec_fetch_s = ~m1_n & ~mreq_n & (addr == NMI_VECTOR);

    nmi_pulse_timer #(.WIDTH(8)) u_nmi_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (nmi_load_s),
        .dec        (nmi_dec_s),
        .load_value (NMI_LOAD),
        .zero       (nmi_zero_s)
    );

    nmi_pulse_timer #(.WIDTH(8)) u_ack_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (to_load_s),
        .dec        (to_dec_s),
        .load_value (TO_LOAD),
        .zero       (to_zero_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s    = state_r;
        rec_s      = rec_r;
        viol_s     = viol_r;
        inh_s      = inh_r;
        nmi_s      = nmi_r;
        nmi_load_s = 1'b0;
        nmi_dec_s  = 1'b0;
        to_load_s  = 1'b0;
        to_dec_s   = 1'b0;
        case (state_r)
            IDLE: begin
                nmi_s = 1'b1;
                if (violation_s) begin
                    inh_s   = 1'b1;
                    rec_s   = 1'b0;
                    viol_s  = 1'b1;
                    state_s = INHIBIT;
                end else begin
                    inh_s = 1'b0;
                    rec_s = armed_s;
                end
            end
            INHIBIT: begin
                rec_s = 1'b0;
                if (iorq_n) begin
                    inh_s      = 1'b0;
                    nmi_s      = 1'b0;
                    nmi_load_s = 1'b1;
                    state_s    = NMI_ASSERT;
                end else begin
                    inh_s = 1'b1;
                end
            end
            NMI_ASSERT: begin
                rec_s = 1'b0;
                if (nmi_zero_s) begin
                    nmi_s     = 1'b1;
                    to_load_s = 1'b1;
                    state_s   = NMI_WAIT;
                end else begin
                    nmi_s     = 1'b0;
                    nmi_dec_s = 1'b1;
                end
            end
            NMI_WAIT: begin
                rec_s = 1'b0;
                if (vec_fetch_s) begin
                    state_s = HANDLER;
                end else if (to_zero_s) begin
                    nmi_s      = 1'b0;
                    nmi_load_s = 1'b1;
                    state_s    = NMI_ASSERT;
                end else begin
                    to_dec_s = 1'b1;
                end
            end
            HANDLER: begin
                rec_s = 1'b0;
                if (clear_violation) begin
                    viol_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    viol_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                rec_s   = 1'b0;
                viol_s  = 1'b0;
                inh_s   = 1'b0;
                nmi_s   = 1'b1;
            end
        endcase
    end

    // State, IORQ edge history and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            iorq_d_r <= 1'b1;
            rec_r    <= 1'b0;
            viol_r   <= 1'b0;
            inh_r    <= 1'b0;
            nmi_r    <= 1'b1;
        end else begin
            state_r  <= state_s;
            iorq_d_r <= iorq_n;
            rec_r    <= rec_s;
            viol_r   <= viol_s;
            inh_r    <= inh_s;
            nmi_r    <= nmi_s;
        end
    end

    assign record_isr_en        = rec_r;
    assign io_violation_occured = viol_r;
    assign io_inhibit           = inh_r;
    assign nmi_n                = nmi_r;

`ifdef IO_TRAP_COUNTER_EN
    logic [7:0] trap_cnt_r;
    logic       trap_hit_s;

    assign trap_hit_s = (state_r == IDLE) & violation_s;

    // Saturating count of trap entries; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap_cnt_r <= 8'h00;
        end else if (trap_hit_s && (trap_cnt_r != 8'hFF)) begin
            trap_cnt_r <= trap_cnt_r + 8'd1;
        end else begin
            trap_cnt_r <= trap_cnt_r;
        end
    end

    assign trap_count = trap_cnt_r;
`else
    assign trap_count = 8'h00;
`endif

endmodule

// File: tb/tb_io_trap_sequencer.sv
// Scoreboard bench for io_trap_sequencer: stimulus pushes hand-computed
// expected outputs, a monitor pops and compares after each sampling point.
module tb_io_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m1_n = 1'b1;
    logic        mreq_n = 1'b1;
    logic        iorq_n = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        user_mode = 1'b1;
    logic        trap_en = 1'b1;
    logic        clear_violation = 1'b0;
    logic        record_isr_en;
    logic        io_violation_occured;
    logic        io_inhibit;
    logic        nmi_n;
    logic [7:0]  trap_count;

    typedef struct {
        string       nm;
        logic [11:0] val;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] exp_cnt = 8'h00;
    int         checks = 0;
    int         errors = 0;
    event       chk_now;

    io_trap_sequencer dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .m1_n                 (m1_n),
        .mreq_n               (mreq_n),
        .iorq_n               (iorq_n),
        .addr                 (addr),
        .user_mode            (user_mode),
        .trap_en              (trap_en),
        .clear_violation      (clear_violation),
        .record_isr_en        (record_isr_en),
        .io_violation_occured (io_violation_occured),
        .io_inhibit           (io_inhibit),
        .nmi_n                (nmi_n),
        .trap_count           (trap_count)
    );

    always #5 clk = ~clk;

    // Monitor: compare after each rising edge, or on demand for async events.
    always begin
        @(posedge clk or chk_now);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({record_isr_en, io_violation_occured, io_inhibit, nmi_n, trap_count} !== mon_e.val) begin
                errors++;
                $display("FAIL %s actual rec/viol/inh/nmi/cnt=%b/%b/%b/%b/%h required=%b/%b/%b/%b/%h",
                         mon_e.nm, record_isr_en, io_violation_occured, io_inhibit, nmi_n, trap_count,
                         mon_e.val[11], mon_e.val[10], mon_e.val[9], mon_e.val[8], mon_e.val[7:0]);
            end
        end
    end

    task automatic push_exp(input string nm, input logic r, input logic v, input logic inh, input logic n);
        exp_t e;
        e.nm  = nm;
        e.val = {r, v, inh, n, exp_cnt};
        exp_q.push_back(e);
    endtask

    // One clock with the current inputs; expectation applies after the next rising edge.
    task automatic step(input string nm, input logic r, input logic v, input logic inh, input logic n);
        push_exp(nm, r, v, inh, n);
        @(negedge clk);
    endtask

    task automatic set_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        addr = 16'h0000; clear_violation = 1'b0;
    endtask

    task automatic bump_cnt();
`ifdef IO_TRAP_COUNTER_EN
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`else
        exp_cnt = 8'h00;
`endif
    endtask

    // Full trap from IDLE (armed, rec=1) back to IDLE with recording re-enabled.
    task automatic trap(input bit retry);
        addr = 16'h00A0; iorq_n = 1'b0; bump_cnt();
        step("trap_hit", 1'b0, 1'b1, 1'b1, 1'b1);
        step("trap_hold", 1'b0, 1'b1, 1'b1, 1'b1);
        iorq_n = 1'b1; addr = 16'h0000;
        for (int k = 0; k < 4; k++) step("nmi_low", 1'b0, 1'b1, 1'b0, 1'b0);
        step("nmi_release", 1'b0, 1'b1, 1'b0, 1'b1);
        clear_violation = 1'b1;
        step("clear_ignored_wait", 1'b0, 1'b1, 1'b0, 1'b1);
        clear_violation = 1'b0;
        if (retry) begin
            for (int k = 0; k < 253; k++) step("ack_wait_high", 1'b0, 1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 4; k++) step("retry_nmi_low", 1'b0, 1'b1, 1'b0, 1'b0);
            step("retry_release", 1'b0, 1'b1, 1'b0, 1'b1);
        end
        m1_n = 1'b0; mreq_n = 1'b0; addr = 16'h0066;
        step("vector_fetch", 1'b0, 1'b1, 1'b0, 1'b1);
        m1_n = 1'b1; mreq_n = 1'b1; addr = 16'h00A0; iorq_n = 1'b0; user_mode = 1'b0;
        step("handler_io_free", 1'b0, 1'b1, 1'b0, 1'b1);
        iorq_n = 1'b1; addr = 16'h0000; user_mode = 1'b1; clear_violation = 1'b1;
        step("handler_clear", 1'b0, 1'b0, 1'b0, 1'b1);
        clear_violation = 1'b0;
        step("rearm", 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        step("reset_state", 1'b0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        step("idle_rec", 1'b1, 1'b0, 1'b0, 1'b1);

        addr = 16'h0041; iorq_n = 1'b0;
        step("legal_port", 1'b1, 1'b0, 1'b0, 1'b1);
        step("legal_port_hold", 1'b1, 1'b0, 1'b0, 1'b1);
        set_idle();
        step("legal_done", 1'b1, 1'b0, 1'b0, 1'b1);

        trap(1'b1);

        m1_n = 1'b0; iorq_n = 1'b0; addr = 16'h0000;
        step("int_ack", 1'b1, 1'b0, 1'b0, 1'b1);
        step("int_ack_hold", 1'b1, 1'b0, 1'b0, 1'b1);
        set_idle();
        step("int_ack_done", 1'b1, 1'b0, 1'b0, 1'b1);

        trap_en = 1'b0; addr = 16'h00A0; iorq_n = 1'b0;
        step("trap_disabled", 1'b0, 1'b0, 1'b0, 1'b1);
        set_idle();
        step("trap_disabled_done", 1'b0, 1'b0, 1'b0, 1'b1);
        trap_en = 1'b1;
        step("trap_reenabled", 1'b1, 1'b0, 1'b0, 1'b1);

        clear_violation = 1'b1;
        step("clear_in_idle", 1'b1, 1'b0, 1'b0, 1'b1);
        clear_violation = 1'b0;

        addr = 16'h00FF; iorq_n = 1'b0; bump_cnt();
        step("trap2_hit", 1'b0, 1'b1, 1'b1, 1'b1);
        iorq_n = 1'b1; addr = 16'h0000;
        step("trap2_nmi", 1'b0, 1'b1, 1'b0, 1'b0);
        step("trap2_nmi_b", 1'b0, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0; exp_cnt = 8'h00;
        push_exp("async_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        -> chk_now;
        @(negedge clk);
        reset_n = 1'b1;
        set_idle();
        step("post_reset", 1'b1, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 300; t++) trap(1'b0);
        step("count_final", 1'b1, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_trap_sequencer.md
Name: io_trap_sequencer

Overview:
- Sequences the MegaMapper Nabu I/O-protection path: watches Z80 bus cycles while the control register selects user mode, and detects I/O accesses outside the permitted port window.
- On a violation it suppresses the access, freezes the instruction-capture register, and raises the violation flag.
- It then pulses NMI and tracks the supervisor handler until the violation is cleared.
- Drives record_isr_en and io_violation_occured into the register block; takes user_mode/trap_en from its ctrl_out.

Parameters:
- ALLOW_BASE, 8'h40, permitted user port base.
- ALLOW_MASK, 8'hC0, port bits compared against ALLOW_BASE.
- NMI_CYCLES, 4, clocks nmi_n is held low per pulse (1..15).
- ACK_TIMEOUT, 255, clocks to wait for the NMI vector fetch before re-pulsing (1..255).

Ports:
- clk  in  1  Z80 CPU clock; all bus inputs sampled on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m1_n  in  1  Z80 M1.
- mreq_n  in  1  Z80 MREQ.
- iorq_n  in  1  Z80 IORQ.
- addr  in  16  Z80 address bus.
- user_mode  in  1  ctrl_out[0]: CPU running untrusted code.
- trap_en  in  1  ctrl_out[1]: protection armed.
- clear_violation  in  1  one-clock pulse from the supervisor write-decode.
- record_isr_en  out  1  allow opcode capture on the M1 rising edge.
- io_violation_occured  out  1  sticky violation flag.
- io_inhibit  out  1  block the current I/O cycle from reaching the bus.
- nmi_n  out  1  NMI to CPU, active low.
- trap_count  out  8  saturating violation count (see Optional Feature).

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-trap): state=IDLE, record_isr_en=0, io_violation_occured=0, io_inhibit=0, nmi_n=1, counters=0. All outputs are registered.
- I/O cycle qualifier: iorq_n=0 and m1_n=1. iorq_n=0 with m1_n=0 (interrupt acknowledge) is never a violation.
- Falling edge of iorq_n is detected against a one-clock-delayed copy.
- Violation: qualified falling edge, and user_mode=1, and trap_en=1, and (addr[7:0] & ALLOW_MASK) != ALLOW_BASE.
- IDLE:
  - record_isr_en = user_mode & trap_en.
  - On violation, in the same clock: io_inhibit=1, record_isr_en=0, io_violation_occured=1; go to INHIBIT. This freezes the trapping opcode before the next M1 rising edge.
- INHIBIT: hold io_inhibit=1 until iorq_n samples 1, then io_inhibit=0, load the NMI counter, nmi_n=0; go to NMI_ASSERT.
- NMI_ASSERT: nmi_n=0 for exactly NMI_CYCLES clocks, then nmi_n=1; load the timeout counter; go to NMI_WAIT.
- NMI_WAIT:
  - Vector fetch (m1_n=0, mreq_n=0, addr=16'h0066) goes to HANDLER.
  - Timeout counter reaching 0 re-enters NMI_ASSERT (retry indefinitely).
- HANDLER:
  - record_isr_en=0; io_violation_occured held at 1.
  - clear_violation=1 clears the flag and returns to IDLE; record_isr_en is re-evaluated the next clock.
- clear_violation is ignored in every state except HANDLER.
- Changes to user_mode/trap_en outside IDLE do not abort a trap in progress.
- A new violation cannot be detected outside IDLE. I/O cycles during INHIBIT..HANDLER are never inhibited, because the handler runs in supervisor mode.
- Counters never wrap below 0. NMI_CYCLES=1 gives a one-clock pulse.

Optional Feature:
- Macro: IO_TRAP_COUNTER_EN.
- Defined: trap_count increments on each IDLE->INHIBIT transition, saturates at 8'hFF, and clears only on reset.
- Undefined: trap_count is tied to 8'h00 and no counter flops are built.

Decomposition:
- Shared package (trap_pkg): state encoding constants (IDLE, INHIBIT, NMI_ASSERT, NMI_WAIT, HANDLER), the NMI vector constant 16'h0066, and the ctrl_out bit indices (USER_MODE_BIT=0, TRAP_EN_BIT=1).
- Sub-module nmi_pulse_timer: load/count-down/zero-flag counter, instanced twice (NMI width and ack timeout).

Test Plan:
- user_mode=1, trap_en=1, OUT to port 8'h41 -> io_inhibit stays 0, record_isr_en stays 1, nmi_n stays 1.
- user_mode=1, trap_en=1, OUT to port 8'hA0 -> in the same clock as the IORQ falling edge: io_inhibit=1, violation=1, record_isr_en=0. On iorq_n rise: nmi_n low exactly 4 clocks.
- After the violation, with no fetch at 16'h0066 -> after 255 clocks a second 4-clock nmi_n pulse. A fetch at 16'h0066 then clear_violation -> IDLE, and record_isr_en=1 the next clock.
- Interrupt acknowledge (m1_n=0, iorq_n=0, addr=8'h00) in user mode -> no trap. Illegal port with trap_en=0 -> no trap.
- Assert reset_n=0 during NMI_ASSERT -> nmi_n=1 and all flags 0 immediately. clear_violation pulsed in IDLE -> no effect.
- With IO_TRAP_COUNTER_EN: 300 violations -> trap_count=8'hFF. Without the macro -> trap_count stays 8'h00.
